// File: rtl/fib.sv
// Forwarding Information Base for the NDN router.
// Holds a small table of MSB-aligned name prefixes. The PIT can request a
// longest-prefix-match lookup, which scans one entry per clock. Incoming
// data packets are held until the PIT accepts or rejects them. Accepted
// prefixes are learned into the table and forwarded back to the PIT.
module fib #(
   parameter int NUM_ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pit_in_prefix,
   input  logic [5:0]  pit_in_len,
   input  logic        fib_out_bit,
   input  logic        start_send_to_pit,
   input  logic        rejected,
   input  logic [5:0]  data_in_len,
   input  logic [63:0] data_in_prefix,
   input  logic        data_ready,
   input  logic [7:0]  data_in,
   output logic [5:0]  pit_out_len,
   output logic [63:0] pit_out_prefix,
   output logic        prefix_ready,
   output logic [7:0]  out_data,
   output logic [63:0] longest_matching_prefix,
   output logic [5:0]  longest_matching_prefix_len,
   output logic        ready_for_data,
   output logic        clk_out
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WAIT_DECISION,
      SEND
   } state_t;

   state_t state;
   state_t state_next;

   // Table storage: one valid bit, prefix and length per entry
   logic [NUM_ENTRIES-1:0] entry_valid;
   logic [63:0]            entry_prefix [NUM_ENTRIES];
   logic [5:0]             entry_len    [NUM_ENTRIES];
   logic [IDX_W-1:0]       repl_ptr;

   // Lookup context
   logic [63:0]            query_prefix;
   logic [5:0]             query_len;
   logic [IDX_W-1:0]       lookup_idx;
   logic [63:0]            best_prefix;
   logic [5:0]             best_len;

   // Pending data packet context
   logic [63:0]            pkt_prefix;
   logic [5:0]             pkt_len;

   // Derived combinational signals
   logic                   lookup_last;
   logic                   cur_match;
   logic [63:0]            cand_prefix;
   logic [5:0]             cand_len;
   logic [63:0]            pkt_masked;
   logic                   dup_found;
   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic                   accept;
   logic                   insert_en;

   // Top-len bits set; a length of 0 yields an empty mask
   function automatic logic [63:0] len_mask(input logic [5:0] len);
      return ~({64{1'b1}} >> len);
   endfunction

   assign clk_out        = clk;
   assign ready_for_data = (state == IDLE);
   assign lookup_last    = (lookup_idx == IDX_W'(NUM_ENTRIES - 1));
   assign accept         = (state == WAIT_DECISION) && !rejected && start_send_to_pit;
   assign insert_en      = accept && (pkt_len != 6'd0) && !dup_found;

   // Evaluate the entry under the scan index against the query and fold it into the running best
   always_comb begin
      cur_match   = 1'b0;
      cand_prefix = best_prefix;
      cand_len    = best_len;
      if (entry_valid[lookup_idx]
          && (entry_len[lookup_idx] != 6'd0)
          && (entry_len[lookup_idx] <= query_len)
          && ((query_prefix & len_mask(entry_len[lookup_idx])) == entry_prefix[lookup_idx])) begin
         cur_match = 1'b1;
      end
      if (cur_match && (entry_len[lookup_idx] > best_len)) begin
         cand_prefix = entry_prefix[lookup_idx];
         cand_len    = entry_len[lookup_idx];
      end
   end

   // Search the table for a duplicate of the pending prefix and for the lowest free slot
   always_comb begin
      pkt_masked = pkt_prefix & len_mask(pkt_len);
      dup_found  = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!entry_valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (entry_valid[i] && (entry_prefix[i] == pkt_masked) && (entry_len[i] == pkt_len)) begin
            dup_found = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a lookup request beats a data packet, a reject beats an accept
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fib_out_bit) begin
               state_next = LOOKUP;
            end else if (data_ready) begin
               state_next = WAIT_DECISION;
            end
         end
         LOOKUP: begin
            if (lookup_last) begin
               state_next = IDLE;
            end
         end
         WAIT_DECISION: begin
            if (rejected) begin
               state_next = IDLE;
            end else if (start_send_to_pit) begin
               state_next = SEND;
            end
         end
         SEND: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Table update: learn accepted prefixes, filling free slots before round-robin replacement
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_valid <= '0;
         repl_ptr    <= '0;
      end else if (insert_en) begin
         if (free_found) begin
            entry_valid[free_idx]  <= 1'b1;
            entry_prefix[free_idx] <= pkt_masked;
            entry_len[free_idx]    <= pkt_len;
         end else begin
            entry_valid[repl_ptr]  <= 1'b1;
            entry_prefix[repl_ptr] <= pkt_masked;
            entry_len[repl_ptr]    <= pkt_len;
            repl_ptr               <= repl_ptr + 1'b1;
         end
      end
   end

   // Request capture, lookup scan and the registered result/forwarding outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         query_prefix                <= '0;
         query_len                   <= '0;
         lookup_idx                  <= '0;
         best_prefix                 <= '0;
         best_len                    <= '0;
         pkt_prefix                  <= '0;
         pkt_len                     <= '0;
         pit_out_prefix              <= '0;
         pit_out_len                 <= '0;
         out_data                    <= '0;
         prefix_ready                <= 1'b0;
         longest_matching_prefix     <= '0;
         longest_matching_prefix_len <= '0;
      end else begin
         prefix_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (fib_out_bit) begin
                  query_prefix <= pit_in_prefix;
                  query_len    <= pit_in_len;
                  best_prefix  <= '0;
                  best_len     <= '0;
                  lookup_idx   <= '0;
               end else if (data_ready) begin
                  pkt_prefix <= data_in_prefix;
                  pkt_len    <= data_in_len;
               end
            end
            LOOKUP: begin
               best_prefix <= cand_prefix;
               best_len    <= cand_len;
               lookup_idx  <= lookup_idx + 1'b1;
               if (lookup_last) begin
                  longest_matching_prefix     <= cand_prefix;
                  longest_matching_prefix_len <= cand_len;
               end
            end
            WAIT_DECISION: begin
               if (accept) begin
                  pit_out_prefix <= pkt_masked;
                  pit_out_len    <= pkt_len;
                  out_data       <= data_in;
                  prefix_ready   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fib.sv
// Directed self-checking bench for the FIB: lookup latency and results,
// data reject/accept handshake, learning, replacement and reset behaviour.
module tb_fib;

   localparam int N = 8;

   logic        clk;
   logic        rst;
   logic [63:0] pit_in_prefix;
   logic [5:0]  pit_in_len;
   logic        fib_out_bit;
   logic        start_send_to_pit;
   logic        rejected;
   logic [5:0]  data_in_len;
   logic [63:0] data_in_prefix;
   logic        data_ready;
   logic [7:0]  data_in;
   logic [5:0]  pit_out_len;
   logic [63:0] pit_out_prefix;
   logic        prefix_ready;
   logic [7:0]  out_data;
   logic [63:0] longest_matching_prefix;
   logic [5:0]  longest_matching_prefix_len;
   logic        ready_for_data;
   logic        clk_out;

   int checks = 0;
   int errors = 0;
   int pr_count = 0;

   fib #(.NUM_ENTRIES(N)) dut (
      .clk                         (clk),
      .rst                         (rst),
      .pit_in_prefix               (pit_in_prefix),
      .pit_in_len                  (pit_in_len),
      .fib_out_bit                 (fib_out_bit),
      .start_send_to_pit           (start_send_to_pit),
      .rejected                    (rejected),
      .data_in_len                 (data_in_len),
      .data_in_prefix              (data_in_prefix),
      .data_ready                  (data_ready),
      .data_in                     (data_in),
      .pit_out_len                 (pit_out_len),
      .pit_out_prefix              (pit_out_prefix),
      .prefix_ready                (prefix_ready),
      .out_data                    (out_data),
      .longest_matching_prefix     (longest_matching_prefix),
      .longest_matching_prefix_len (longest_matching_prefix_len),
      .ready_for_data              (ready_for_data),
      .clk_out                     (clk_out)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every cycle in which the forwarding strobe is high
   always @(negedge clk) begin
      if (prefix_ready === 1'b1) pr_count++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the control strobes for n cycles, then release them
   task automatic applyStimulus(input logic fob, input logic ss, input logic rj, input int n);
      fib_out_bit       = fob;
      start_send_to_pit = ss;
      rejected          = rj;
      step(n);
      fib_out_bit       = 1'b0;
      start_send_to_pit = 1'b0;
      rejected          = 1'b0;
   endtask

   function automatic logic [63:0] pfx(input int i);
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      return {b, 56'h0};
   endfunction

   task automatic doLookup(input string tag, input logic [63:0] q, input logic [5:0] ql,
                           input logic [63:0] exp_p, input logic [5:0] exp_l);
      int cycles;
      pit_in_prefix = q;
      pit_in_len    = ql;
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      cycles = 0;
      while (ready_for_data !== 1'b1 && cycles < 64) begin
         step(1);
         cycles++;
      end
      checkOutput({tag, "_latency"}, 64'(cycles), 64'(N));
      checkOutput({tag, "_prefix"}, longest_matching_prefix, exp_p);
      checkOutput({tag, "_len"}, 64'(longest_matching_prefix_len), 64'(exp_l));
   endtask

   task automatic doInsert(input string tag, input logic [63:0] p, input logic [5:0] l,
                           input logic [7:0] byte_val, input int wait_cycles,
                           input logic [63:0] exp_p);
      int pc;
      data_in_prefix = p;
      data_in_len    = l;
      data_ready     = 1'b1;
      step(1);
      data_ready = 1'b0;
      checkOutput({tag, "_waiting"}, 64'(ready_for_data), 64'd0);
      step(wait_cycles);
      data_in = byte_val;
      pc = pr_count;
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      checkOutput({tag, "_prefix_ready"}, 64'(prefix_ready), 64'd1);
      checkOutput({tag, "_out_prefix"}, pit_out_prefix, exp_p);
      checkOutput({tag, "_out_len"}, 64'(pit_out_len), 64'(l));
      checkOutput({tag, "_out_data"}, 64'(out_data), 64'(byte_val));
      step(1);
      checkOutput({tag, "_strobe_once"}, 64'(pr_count), 64'(pc + 1));
      checkOutput({tag, "_idle"}, 64'(ready_for_data), 64'd1);
   endtask

   initial begin
      int pc;
      int cycles;
      rst               = 1'b1;
      pit_in_prefix     = '0;
      pit_in_len        = '0;
      fib_out_bit       = 1'b0;
      start_send_to_pit = 1'b0;
      rejected          = 1'b0;
      data_in_len       = '0;
      data_in_prefix    = '0;
      data_ready        = 1'b0;
      data_in           = '0;
      step(2);

      $display("[TB] reset state");
      checkOutput("rst_ready", 64'(ready_for_data), 64'd1);
      checkOutput("rst_prefix_ready", 64'(prefix_ready), 64'd0);
      checkOutput("rst_lmp", longest_matching_prefix, 64'd0);
      checkOutput("rst_lmp_len", 64'(longest_matching_prefix_len), 64'd0);
      checkOutput("rst_out_prefix", pit_out_prefix, 64'd0);
      checkOutput("rst_out_len", 64'(pit_out_len), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'd0);
      checkOutput("clk_out_high", 64'(clk_out), 64'(clk));
      rst = 1'b0;
      step(1);

      $display("[TB] lookup on empty table");
      doLookup("empty_miss", 64'h0000FFFF0000FFFF, 6'd10, 64'd0, 6'd0);

      $display("[TB] data packet rejected");
      data_in_prefix = 64'h0000FFFF0000FFFF;
      data_in_len    = 6'd10;
      data_ready     = 1'b1;
      pc             = pr_count;
      step(5);
      checkOutput("rej_waiting", 64'(ready_for_data), 64'd0);
      data_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      checkOutput("rej_idle", 64'(ready_for_data), 64'd1);
      checkOutput("rej_no_strobe", 64'(pr_count), 64'(pc));

      $display("[TB] reject beats accept");
      data_ready = 1'b1;
      step(1);
      data_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      step(1);
      checkOutput("both_idle", 64'(ready_for_data), 64'd1);
      checkOutput("both_no_strobe", 64'(pr_count), 64'(pc));
      doLookup("rej_still_empty", 64'h0000FFFF0000FFFF, 6'd10, 64'd0, 6'd0);

      $display("[TB] data packet accepted");
      doInsert("acc", 64'h0000FFFF0000FFFF, 6'd10, 8'h5A, 10, 64'h0000000000000000);
      doLookup("acc_hit", 64'h0000FFFF0000FFFF, 6'd10, 64'h0000000000000000, 6'd10);

      $display("[TB] longest prefix match");
      doInsert("ins_ff8", 64'hFF00000000000000, 6'd8, 8'h11, 0, 64'hFF00000000000000);
      doInsert("ins_ffab16", 64'hFFAB000000000000, 6'd16, 8'h22, 0, 64'hFFAB000000000000);
      doLookup("lpm_16", 64'hFFAB123400000000, 6'd32, 64'hFFAB000000000000, 6'd16);
      doLookup("lpm_8", 64'hFF12000000000000, 6'd32, 64'hFF00000000000000, 6'd8);
      doLookup("lpm_short", 64'hFFAB123400000000, 6'd4, 64'd0, 6'd0);
      doInsert("masked_store", 64'hABCDEF0123456789, 6'd12, 8'h33, 0, 64'hABC0000000000000);
      doLookup("masked_hit", 64'hABCFFFFFFFFFFFFF, 6'd20, 64'hABC0000000000000, 6'd12);

      $display("[TB] replacement after table fills");
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      for (int i = 0; i <= N; i++) begin
         doInsert($sformatf("fill%0d", i), pfx(i), 6'd8, 8'(i), 0, pfx(i));
      end
      doLookup("evicted_p0", pfx(0), 6'd8, 64'd0, 6'd0);
      doLookup("newest_p8", pfx(N), 6'd8, pfx(N), 6'd8);
      doInsert("reinsert_p3", pfx(3), 6'd8, 8'h77, 0, pfx(3));
      doInsert("ins_p9", pfx(N + 1), 6'd8, 8'h99, 0, pfx(N + 1));
      doLookup("kept_p2", pfx(2), 6'd8, pfx(2), 6'd8);
      doLookup("evicted_p1", pfx(1), 6'd8, 64'd0, 6'd0);
      doLookup("kept_p3", pfx(3), 6'd8, pfx(3), 6'd8);
      doLookup("kept_p8", pfx(N), 6'd8, pfx(N), 6'd8);

      $display("[TB] lookup and data in the same cycle");
      data_in_prefix = 64'h1234000000000000;
      data_in_len    = 6'd16;
      data_ready     = 1'b1;
      pit_in_prefix  = pfx(N + 1);
      pit_in_len     = 6'd8;
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("simul_lookup_busy", 64'(ready_for_data), 64'd0);
      cycles = 0;
      while (ready_for_data !== 1'b1 && cycles < 64) begin
         step(1);
         cycles++;
      end
      checkOutput("simul_latency", 64'(cycles), 64'(N));
      checkOutput("simul_prefix", longest_matching_prefix, pfx(N + 1));
      step(1);
      checkOutput("simul_data_captured", 64'(ready_for_data), 64'd0);
      data_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      checkOutput("simul_rejected_idle", 64'(ready_for_data), 64'd1);

      $display("[TB] reset during lookup");
      pit_in_prefix = pfx(N + 1);
      pit_in_len    = 6'd8;
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      checkOutput("midrst_ready", 64'(ready_for_data), 64'd1);
      checkOutput("midrst_lmp", longest_matching_prefix, 64'd0);
      checkOutput("midrst_lmp_len", 64'(longest_matching_prefix_len), 64'd0);
      checkOutput("midrst_out_prefix", pit_out_prefix, 64'd0);
      checkOutput("midrst_out_len", 64'(pit_out_len), 64'd0);
      checkOutput("midrst_out_data", 64'(out_data), 64'd0);
      checkOutput("midrst_prefix_ready", 64'(prefix_ready), 64'd0);
      doLookup("midrst_table_cleared", pfx(N + 1), 6'd8, 64'd0, 6'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fib.md
Name: fib

Overview:
- Forwarding Information Base for the NDN router: a small table of name prefixes with longest-prefix-match lookup.
- Outgoing path: the PIT presents an interest prefix and the FIB returns the longest stored prefix that covers it.
- Incoming path: the FIB captures a data packet's prefix, then waits for the PIT's reject/accept decision. An accepted prefix is learned into the table and forwarded to the PIT.

Parameters:
NUM_ENTRIES, 8, number of table entries (power of two, ≥2); widths are fixed (prefix 64, length 6, data 8).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pit_in_prefix  in  64  interest prefix from PIT, MSB-aligned
pit_in_len  in  6  interest prefix length in bits (counted from bit 63)
fib_out_bit  in  1  lookup request strobe from PIT
start_send_to_pit  in  1  PIT accepts the pending data packet
rejected  in  1  PIT rejects the pending data packet
data_in_len  in  6  incoming data prefix length in bits
data_in_prefix  in  64  incoming data prefix, MSB-aligned
data_ready  in  1  incoming data packet valid
data_in  in  8  incoming payload byte
pit_out_len  out  6  learned prefix length sent to PIT
pit_out_prefix  out  64  learned prefix sent to PIT (masked)
prefix_ready  out  1  one-cycle strobe: pit_out_* and out_data valid
out_data  out  8  payload byte forwarded to PIT
longest_matching_prefix  out  64  lookup result prefix (masked); 0 on miss
longest_matching_prefix_len  out  6  lookup result length; 0 = miss
ready_for_data  out  1  high when FSM is IDLE (can accept a request)
clk_out  out  1  combinational copy of clk

Behaviour:
- Entry format: valid, prefix[63:0], len[5:0].
- Stored prefixes are masked: bits below the top len bits are zeroed. mask(len) has bits 63..64-len set; len 0 gives an empty mask.
- Match rule: entry e matches query (q,ql) iff e.valid, 1≤e.len≤ql, and (q & mask(e.len)) == e.prefix.
- FSM states: IDLE, LOOKUP, WAIT_DECISION, SEND. ready_for_data = (state==IDLE).
- Reset (synchronous):
  - All entries invalid; replacement pointer 0; state IDLE.
  - pit_out_*, out_data, longest_matching_* all 0; prefix_ready 0; ready_for_data 1.
- IDLE:
  - fib_out_bit=1: latch pit_in_prefix/len, clear best, idx←0, go to LOOKUP.
  - Otherwise, data_ready=1: latch data_in_prefix/len, go to WAIT_DECISION.
  - fib_out_bit has priority over data_ready.
  - rejected/start_send_to_pit are ignored in IDLE.
- LOOKUP:
  - One entry evaluated per clock, idx 0..NUM_ENTRIES-1.
  - best is updated only when the entry matches with len strictly greater than best len, so on equal length the lowest index wins.
  - On the edge evaluating the last entry: drive longest_matching_prefix/len from best (0/0 if no match), go to IDLE.
  - Latency is NUM_ENTRIES cycles from the capture edge to result-valid. ready_for_data rising marks completion.
  - Results hold until the next lookup completes. Inputs are ignored during LOOKUP.
- WAIT_DECISION (waits indefinitely):
  - rejected=1: discard the packet, go to IDLE; the table is unchanged.
  - Else start_send_to_pit=1: insert, go to SEND. rejected has priority if both are high.
- Insert rules:
  - A latched len of 0 is never inserted.
  - If a valid entry with the identical masked prefix and len exists, there is no change.
  - Else write the lowest-index invalid slot.
  - If the table is full, overwrite the slot at the replacement pointer, then pointer+1 mod NUM_ENTRIES.
- SEND (one cycle):
  - prefix_ready=1; pit_out_prefix = masked latched prefix; pit_out_len = latched len; out_data = data_in registered at entry to SEND.
  - Next state IDLE. pit_out_* and out_data hold afterwards; prefix_ready returns to 0.
- A new entry becomes visible to any lookup starting after SEND.
- clk_out = clk (pure wire).

Test Plan:
- Reset then lookup 0x0000FFFF0000FFFF len 10 → NUM_ENTRIES cycles later: ready_for_data=1, longest_matching_prefix=0, len=0 (miss).
- Data 0x0000FFFF0000FFFF len 10, data_ready held 5 cycles, then rejected=1 → FSM returns to IDLE, no prefix_ready, table still empty (a repeat lookup misses).
- Same data, then start_send_to_pit=1 after 10 cycles with data_in=0x5A:
  - prefix_ready pulses once with pit_out_prefix=0x0000000000000000, pit_out_len=10, out_data=0x5A.
  - A following lookup of 0x0000FFFF0000FFFF len 10 returns len=10 (hit).
- Insert 0xFF00000000000000 len 8 and 0xFFAB000000000000 len 16. Then:
  - Lookup 0xFFAB123400000000 len 32 → 0xFFAB000000000000/16.
  - Lookup 0xFF12000000000000 len 32 → 0xFF00000000000000/8.
  - Lookup with len 4 → miss.
- Insert NUM_ENTRIES+1 distinct prefixes → the entry at slot 0 is overwritten; the first prefix now misses and the last one hits. Re-inserting an existing prefix creates no duplicate.
- fib_out_bit and data_ready asserted in the same cycle → lookup runs. data_ready, still held after the lookup completes, is then captured. A mid-LOOKUP rst returns to IDLE with all outputs 0.
